// File: rtl/imem_loader_if.sv
// Byte-stream input and IMEM write port of the program loader.
// master: the loader side; slave: host byte source / IMEM side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_write_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_write_instr;

  modport master (
    input  in_valid, in_data,
    output in_ready, imem_write_en, imem_addr, imem_write_instr
  );
  modport slave (
    output in_valid, in_data,
    input  in_ready, imem_write_en, imem_addr, imem_write_instr
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: packs little-endian bytes into words,
// writes them to IMEM, verifies an 8-bit checksum and gates the CPU reset.
module imem_loader #(
  parameter int          DEPTH     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  imem_loader_if.master   bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            error
);
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  sum;
  logic [23:0] asm_q;     // first three bytes of the word being assembled
  logic        xfer;
  logic [15:0] len_next;

  assign xfer     = bus.in_valid && bus.in_ready;
  assign len_next = {bus.in_data, len[7:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= S_IDLE;
      len                  <= '0;
      word_idx             <= '0;
      byte_idx             <= '0;
      sum                  <= '0;
      asm_q                <= '0;
      bus.in_ready         <= 1'b0;
      bus.imem_write_en    <= 1'b0;
      bus.imem_addr        <= BASE_ADDR;
      bus.imem_write_instr <= '0;
      cpu_hold             <= 1'b1;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      error                <= 1'b0;
    end else begin
      bus.imem_write_en <= 1'b0;
      // The write cycle blocks the stream for one cycle; reopen afterwards.
      if (bus.imem_write_en) bus.in_ready <= 1'b1;

      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN_LO;
            done         <= 1'b0;
            error        <= 1'b0;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            word_idx     <= '0;
            byte_idx     <= '0;
            sum          <= '0;
            bus.in_ready <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len[7:0] <= bus.in_data;
            state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len[15:8] <= bus.in_data;
            if (len_next == 16'd0 || len_next > 16'(DEPTH)) begin
              state        <= S_ERR;
              error        <= 1'b1;
              busy         <= 1'b0;
              bus.in_ready <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            sum      <= sum + bus.in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              bus.imem_write_en    <= 1'b1;
              bus.imem_write_instr <= {bus.in_data, asm_q};
              bus.imem_addr        <= BASE_ADDR + {word_idx[13:0], 2'b00};
              bus.in_ready         <= 1'b0;
              word_idx             <= word_idx + 16'd1;
              if (word_idx + 16'd1 == len) state <= S_CHECK;
            end else begin
              asm_q <= {bus.in_data, asm_q[23:8]};
            end
          end
        end
        S_CHECK: begin
          if (xfer) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.in_data == sum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader with a frame-level reference model.
module tb_imem_loader;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, error;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(rst_n), .start(start), .bus(bus.master),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Write monitor: collects every IMEM write and flags protocol slips.
  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  int rdy_viol = 0;
  int dbl_viol = 0;
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (bus.imem_write_en) begin
      got_a.push_back(bus.imem_addr);
      got_d.push_back(bus.imem_write_instr);
      if (bus.in_ready) rdy_viol <= rdy_viol + 1;
      if (prev_we) dbl_viol <= dbl_viol + 1;
    end
    prev_we <= bus.imem_write_en;
  end

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int t;
    while (int'($urandom_range(99)) < gap_pct) begin
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout in_ready=%0b want 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Sends LEN + data + checksum (checksum offset by chk_delta); stops after LEN if N is illegal.
  task automatic send_frame(input logic [31:0] w[$], input int n, input logic [7:0] chk_delta,
                            input int gap);
    logic [7:0] s;
    logic [15:0] n16;
    s = 8'd0;
    n16 = n[15:0];
    send_byte(n16[7:0], gap);
    send_byte(n16[15:8], gap);
    if (n == 0 || n > DEPTH) return;
    foreach (w[i])
      for (int k = 0; k < 4; k++) begin
        send_byte(w[i][8*k +: 8], gap);
        s = s + w[i][8*k +: 8];
      end
    send_byte(s + chk_delta, gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_a.delete();
    got_d.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.in_ready, bus.imem_write_en, bus.imem_addr, bus.imem_write_instr, cpu_hold, busy, done, error}
        !== {1'b0, 1'b0, BASE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values rdy=%0b we=%0b a=%h d=%h hold=%0b busy=%0b done=%0b err=%0b want 0 0 %h 0 1 0 0 0",
               bus.in_ready, bus.imem_write_en, bus.imem_addr, bus.imem_write_instr,
               cpu_hold, busy, done, error, BASE);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [31:0] w[$];
    w = '{32'h0050_0113};
    pulse_start();
    n_checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_busy busy=%0b rdy=%0b want 1 1", busy, bus.in_ready);
    end
    send_frame(w, 1, 8'd0, 0);
    n_checks++;
    if (got_a.size() != 1 || got_a[0] !== BASE || got_d[0] !== 32'h0050_0113) begin
      n_fail++; $display("FAIL single_write n=%0d a=%h d=%h want 1 %h 00500113",
                         got_a.size(), got_a.size() ? got_a[0] : 0, got_d.size() ? got_d[0] : 0, BASE);
    end
    n_checks++;
    if ({done, error, cpu_hold, busy} !== 4'b1000) begin
      n_fail++; $display("FAIL single_flags d/e/h/b=%b want 1000", {done, error, cpu_hold, busy});
    end
  endtask

  task automatic test_three();
    logic [31:0] w[$];
    w = '{32'h0050_0113, 32'h00C0_0193, 32'hFF71_8393};
    pulse_start();
    send_frame(w, 3, 8'd0, 0);
    n_checks++;
    if (got_a.size() != 3) begin
      n_fail++; $display("FAIL three_count got=%0d want 3", got_a.size());
    end else
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_a[i] !== BASE + 32'(4*i) || got_d[i] !== w[i]) begin
          n_fail++; $display("FAIL three_word%0d a=%h d=%h want %h %h", i, got_a[i], got_d[i], BASE + 32'(4*i), w[i]);
        end
      end
    n_checks++;
    if (done !== 1'b1 || dbl_viol != 0) begin
      n_fail++; $display("FAIL three_done done=%0b dbl=%0d want 1 0", done, dbl_viol);
    end
  endtask

  task automatic test_bad_chk();
    logic [31:0] w[$];
    logic [31:0] w1[$];
    w = '{32'h0050_0113, 32'h00C0_0193, 32'hFF71_8393};
    w1 = '{32'hDEAD_BEEF};
    pulse_start();
    send_frame(w, 3, 8'd1, 0);
    n_checks++;
    if (got_a.size() != 3 || got_d[2] !== w[2]) begin
      n_fail++; $display("FAIL badchk_writes n=%0d want 3", got_a.size());
    end
    n_checks++;
    if ({done, error, cpu_hold, busy} !== 4'b0110) begin
      n_fail++; $display("FAIL badchk_flags d/e/h/b=%b want 0110", {done, error, cpu_hold, busy});
    end
    pulse_start();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart_clears err=%0b busy=%0b want 0 1", error, busy);
    end
    // A start while busy must be ignored.
    start = 1'b1; @(negedge clk); start = 1'b0;
    send_frame(w1, 1, 8'd0, 0);
    n_checks++;
    if (done !== 1'b1 || got_a.size() != 1 || got_d[0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL restart_frame done=%0b n=%0d want 1 1", done, got_a.size());
    end
  endtask

  task automatic test_bad_len();
    logic [31:0] w[$];
    int lens[2] = '{0, DEPTH + 1};
    w = '{};
    foreach (lens[j]) begin
      pulse_start();
      send_frame(w, lens[j], 8'd0, 0);
      repeat (2) @(negedge clk);
      n_checks++;
      if (error !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0 || got_a.size() != 0) begin
        n_fail++; $display("FAIL badlen_%0d err=%0b done=%0b rdy=%0b busy=%0b writes=%0d want 1 0 0 0 0",
                           lens[j], error, done, bus.in_ready, busy, got_a.size());
      end
    end
  endtask

  task automatic test_random_64();
    logic [31:0] w[$];
    int bad;
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    pulse_start();
    send_frame(w, DEPTH, 8'd0, 50);
    n_checks++;
    if (got_a.size() != DEPTH || got_a[DEPTH-1] !== BASE + 32'h0000_00FC) begin
      n_fail++; $display("FAIL rand64_count n=%0d want %0d (last at fc)", got_a.size(), DEPTH);
    end else begin
      bad = 0;
      for (int i = 0; i < DEPTH; i++)
        if (got_a[i] !== BASE + 32'(4*i) || got_d[i] !== w[i]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL rand64_data bad_words=%0d want 0", bad);
      end
    end
    n_checks++;
    if (rdy_viol != 0 || dbl_viol != 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL rand64_proto rdy_viol=%0d dbl=%0d done=%0b want 0 0 1", rdy_viol, dbl_viol, done);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 6; f++) begin
      logic [31:0] w[$];
      int n;
      logic [7:0] delta;
      int bad;
      n = $urandom_range(8, 1);
      delta = ($urandom_range(3) == 0) ? 8'($urandom_range(255, 1)) : 8'd0;
      w = '{};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      pulse_start();
      send_frame(w, n, delta, $urandom_range(30));
      bad = (got_a.size() != n) ? 1 : 0;
      if (bad == 0)
        for (int i = 0; i < n; i++)
          if (got_a[i] !== BASE + 32'(4*i) || got_d[i] !== w[i]) bad++;
      n_checks++;
      if (bad != 0) begin
        n_fail++; $display("FAIL b2b%0d_writes n=%0d want %0d bad=%0d", f, got_a.size(), n, bad);
      end
      n_checks++;
      if ({done, error, cpu_hold, busy} !== ((delta == 8'd0) ? 4'b1000 : 4'b0110)) begin
        n_fail++; $display("FAIL b2b%0d_flags d/e/h/b=%b delta=%0d", f, {done, error, cpu_hold, busy}, delta);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[$];
    w = '{32'h1111_2222, 32'h3333_4444};
    pulse_start();
    send_byte(8'd8, 0);
    send_byte(8'd0, 0);
    for (int i = 0; i < 5*4 + 2; i++) send_byte(8'($urandom), 0);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.imem_write_en, bus.imem_addr, bus.imem_write_instr, cpu_hold, busy, done, error}
        !== {1'b0, 1'b0, BASE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midreset_values rdy=%0b we=%0b a=%h d=%h hold=%0b busy=%0b done=%0b err=%0b",
               bus.in_ready, bus.imem_write_en, bus.imem_addr, bus.imem_write_instr,
               cpu_hold, busy, done, error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    send_frame(w, 2, 8'd0, 20);
    n_checks++;
    if (got_a.size() != 2 || got_a[1] !== BASE + 32'd4 || got_d[0] !== w[0] || got_d[1] !== w[1] || done !== 1'b1) begin
      n_fail++; $display("FAIL midreset_reload n=%0d done=%0b want 2 1", got_a.size(), done);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_three();
    test_bad_chk();
    test_bad_len();
    test_random_64();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
